// File: rtl/add8_mon_pkg.sv
// Shared types and widths for the approximate-adder error monitor.
package add8_mon_pkg;

    localparam int SAE_W = 26;
    localparam int ERR_W = 9;
    localparam int SUM_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_e;

    // Accumulate an error magnitude into the SAE register, pinning at all-ones.
    function automatic logic [SAE_W-1:0] sae_sat_add(input logic [SAE_W-1:0] acc,
                                                     input logic [ERR_W-1:0] e);
        logic [SAE_W:0] sum;
        sum = {1'b0, acc} + {{(SAE_W + 1 - ERR_W){1'b0}}, e};
        return sum[SAE_W] ? {SAE_W{1'b1}} : sum[SAE_W-1:0];
    endfunction

endpackage

// File: rtl/add8_absdiff.sv
// Combinational absolute difference of two unsigned sums.
module add8_absdiff
    import add8_mon_pkg::*;
(
    input  logic [SUM_W-1:0] x_i,
    input  logic [SUM_W-1:0] y_i,
    output logic [ERR_W-1:0] d_o
);

    assign d_o = (x_i >= y_i) ? (x_i - y_i) : (y_i - x_i);

endmodule

// File: rtl/add8_err_monitor.sv
// Error statistics monitor for an external approximate 8-bit adder:
// three-stage pipeline (exact sum, |error|, statistics) under a run FSM.
module add8_err_monitor
    import add8_mon_pkg::*;
#(
    parameter int N_MAX = 65536
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             a,
    input  logic [7:0]             b,
    input  logic [SUM_W-1:0]       o_approx,
    input  logic                   last,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(N_MAX):0] smp_cnt,
    output logic [$clog2(N_MAX):0] err_cnt,
    output logic [SAE_W-1:0]       sae,
    output logic [ERR_W-1:0]       wce
);

    localparam int CNT_W = $clog2(N_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_MAX - 1);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             s1_vld_q, s2_vld_q;
    logic [SUM_W-1:0] s1_exact_q, s1_approx_q;
    logic [ERR_W-1:0] s2_err_q, abs_err;
    logic [CNT_W-1:0] smp_q, smp_d, err_q, err_d;
    logic [SAE_W-1:0] sae_q, sae_d;
    logic [ERR_W-1:0] wce_q, wce_d;
    logic             accept, clear;

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign accept   = in_valid && in_ready;
    assign clear    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    assign smp_cnt = smp_q;
    assign err_cnt = err_q;
    assign sae     = sae_q;
    assign wce     = wce_q;

    add8_absdiff u_absdiff (
        .x_i(s1_exact_q),
        .y_i(s1_approx_q),
        .d_o(abs_err)
    );

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    acc_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_ONE;
                    if (last || (acc_cnt_q == LAST_IDX)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Final sample is committed once both stage flags have emptied.
                if (!s1_vld_q && !s2_vld_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        smp_d = smp_q;
        err_d = err_q;
        sae_d = sae_q;
        wce_d = wce_q;
        if (clear) begin
            smp_d = '0;
            err_d = '0;
            sae_d = '0;
            wce_d = '0;
        end else if (s2_vld_q) begin
            smp_d = smp_q + CNT_ONE;
            if (s2_err_q != '0) err_d = err_q + CNT_ONE;
            sae_d = sae_sat_add(sae_q, s2_err_q);
            if (s2_err_q > wce_q) wce_d = s2_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_cnt_q   <= '0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            s2_err_q    <= '0;
            smp_q       <= '0;
            err_q       <= '0;
            sae_q       <= '0;
            wce_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            s1_vld_q    <= accept;
            s2_vld_q    <= s1_vld_q;
            s1_exact_q  <= {1'b0, a} + {1'b0, b};
            s1_approx_q <= o_approx;
            s2_err_q    <= abs_err;
            smp_q       <= smp_d;
            err_q       <= err_d;
            sae_q       <= sae_d;
            wce_q       <= wce_d;
        end
    end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor: default-size instance plus an N_MAX=4 instance.
module tb_add8_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start4 = 1'b0;
    logic        in_valid = 1'b0, in_valid4 = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic [8:0]  o_approx = '0;
    logic        last = 1'b0;

    logic        in_ready, busy, done;
    logic [16:0] smp_cnt, err_cnt;
    logic [25:0] sae;
    logic [8:0]  wce;

    logic        in_ready4, busy4, done4;
    logic [2:0]  smp_cnt4, err_cnt4;
    logic [25:0] sae4;
    logic [8:0]  wce4;

    int tests_run = 0;
    int fails = 0;

    always #5 clk = ~clk;

    add8_err_monitor #(.N_MAX(65536)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .o_approx(o_approx), .last(last), .busy(busy), .done(done),
        .smp_cnt(smp_cnt), .err_cnt(err_cnt), .sae(sae), .wce(wce)
    );

    add8_err_monitor #(.N_MAX(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a), .b(b), .o_approx(o_approx), .last(last), .busy(busy4), .done(done4),
        .smp_cnt(smp_cnt4), .err_cnt(err_cnt4), .sae(sae4), .wce(wce4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                         input logic [8:0] oo, input logic ll);
        in_valid = v; a = aa; b = bb; o_approx = oo; last = ll;
        step();
        in_valid = 1'b0; last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20 && !done; i++) step();
        tests_run++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s: done timeout, got %b want 1", name, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests_run++;
        if ({in_ready, busy, done, in_ready4, busy4, done4} !== 6'b0 || smp_cnt !== 17'd0 ||
            err_cnt !== 17'd0 || sae !== 26'd0 || wce !== 9'd0 || smp_cnt4 !== 3'd0) begin
            fails++;
            $display("FAIL reset: rdy=%b busy=%b done=%b smp=%0d err=%0d sae=%0d wce=%0d want all 0",
                     in_ready, busy, done, smp_cnt, err_cnt, sae, wce);
        end
        step(); step();
        rst_n = 1'b1;
        step();
        tests_run++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: rdy=%b busy=%b want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_single();
        pulse_start();
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_run: rdy=%b busy=%b want 1 1", in_ready, busy);
        end
        drive(1'b1, 8'd3, 8'd4, 9'd7, 1'b1);
        tests_run++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_drain: rdy=%b busy=%b want 0 1", in_ready, busy);
        end
        step(); step();
        tests_run++;
        if (done !== 1'b0 || smp_cnt !== 17'd1) begin
            fails++;
            $display("FAIL single_latency: done=%b smp=%0d want 0 1", done, smp_cnt);
        end
        step();
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0 || smp_cnt !== 17'd1 || err_cnt !== 17'd0 ||
            sae !== 26'd0 || wce !== 9'd0) begin
            fails++;
            $display("FAIL single_stats: done=%b smp=%0d err=%0d sae=%0d wce=%0d want 1 1 0 0 0",
                     done, smp_cnt, err_cnt, sae, wce);
        end
    endtask

    task automatic test_three_beats();
        pulse_start();
        tests_run++;
        if (smp_cnt !== 17'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL three_clear: smp=%0d done=%b want 0 0", smp_cnt, done);
        end
        drive(1'b1, 8'd1,   8'd1,   9'd0,   1'b0);
        drive(1'b1, 8'd10,  8'd20,  9'd31,  1'b0);
        drive(1'b1, 8'd255, 8'd255, 9'd510, 1'b1);
        wait_done("three_done");
        tests_run++;
        if (smp_cnt !== 17'd3 || err_cnt !== 17'd2 || sae !== 26'd3 || wce !== 9'd2) begin
            fails++;
            $display("FAIL three_stats: smp=%0d err=%0d sae=%0d wce=%0d want 3 2 3 2",
                     smp_cnt, err_cnt, sae, wce);
        end
    endtask

    task automatic test_done_drop();
        drive(1'b1, 8'd0, 8'd0, 9'd100, 1'b0);
        drive(1'b1, 8'd0, 8'd0, 9'd100, 1'b1);
        step(); step(); step();
        tests_run++;
        if (done !== 1'b1 || smp_cnt !== 17'd3 || sae !== 26'd3 || wce !== 9'd2) begin
            fails++;
            $display("FAIL done_drop: done=%b smp=%0d sae=%0d wce=%0d want 1 3 3 2",
                     done, smp_cnt, sae, wce);
        end
    endtask

    task automatic test_nmax();
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        a = 8'd1; b = 8'd0; o_approx = 9'd0; last = 1'b0;
        in_valid4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 3) begin
                tests_run++;
                if (in_ready4 !== 1'b0 || busy4 !== 1'b1) begin
                    fails++;
                    $display("FAIL nmax_ready: rdy=%b busy=%b want 0 1", in_ready4, busy4);
                end
            end
        end
        in_valid4 = 1'b0;
        for (int i = 0; i < 20 && !done4; i++) step();
        tests_run++;
        if (done4 !== 1'b1 || smp_cnt4 !== 3'd4 || err_cnt4 !== 3'd4 || sae4 !== 26'd4 ||
            wce4 !== 9'd1) begin
            fails++;
            $display("FAIL nmax_stats: done=%b smp=%0d err=%0d sae=%0d wce=%0d want 1 4 4 4 1",
                     done4, smp_cnt4, err_cnt4, sae4, wce4);
        end
    endtask

    task automatic test_start_in_run();
        pulse_start();
        drive(1'b1, 8'd1, 8'd2, 9'd3, 1'b0);
        drive(1'b1, 8'd5, 8'd5, 9'd9, 1'b0);
        pulse_start();
        tests_run++;
        if (busy !== 1'b1 || smp_cnt !== 17'd1) begin
            fails++;
            $display("FAIL start_ignored: busy=%b smp=%0d want 1 1", busy, smp_cnt);
        end
        drive(1'b1, 8'd7, 8'd7, 9'd14, 1'b1);
        wait_done("start_run_done");
        tests_run++;
        if (smp_cnt !== 17'd3 || err_cnt !== 17'd1 || sae !== 26'd1 || wce !== 9'd1) begin
            fails++;
            $display("FAIL start_run_stats: smp=%0d err=%0d sae=%0d wce=%0d want 3 1 1 1",
                     smp_cnt, err_cnt, sae, wce);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        drive(1'b1, 8'd9, 8'd9, 9'd0, 1'b0);
        drive(1'b1, 8'd9, 8'd9, 9'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || smp_cnt !== 17'd0 ||
            err_cnt !== 17'd0 || sae !== 26'd0 || wce !== 9'd0) begin
            fails++;
            $display("FAIL midrun_reset: rdy=%b busy=%b done=%b smp=%0d sae=%0d wce=%0d want 0s",
                     in_ready, busy, done, smp_cnt, sae, wce);
        end
        step();
        rst_n = 1'b1;
        step(); step(); step();
        tests_run++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || smp_cnt !== 17'd0 || sae !== 26'd0) begin
            fails++;
            $display("FAIL midrun_idle: rdy=%b busy=%b smp=%0d sae=%0d want 0 0 0 0",
                     in_ready, busy, smp_cnt, sae);
        end
        pulse_start();
        drive(1'b1, 8'd0, 8'd0, 9'd1, 1'b1);
        wait_done("midrun_rerun_done");
        tests_run++;
        if (smp_cnt !== 17'd1 || err_cnt !== 17'd1 || sae !== 26'd1 || wce !== 9'd1) begin
            fails++;
            $display("FAIL midrun_rerun: smp=%0d err=%0d sae=%0d wce=%0d want 1 1 1 1",
                     smp_cnt, err_cnt, sae, wce);
        end
    endtask

    task automatic test_back_to_back_gaps();
        pulse_start();
        drive(1'b1, 8'd0, 8'd0, 9'd2, 1'b0);
        drive(1'b0, 8'd0, 8'd0, 9'd2, 1'b0);
        drive(1'b1, 8'd0, 8'd0, 9'd2, 1'b1);
        drive(1'b0, 8'd0, 8'd0, 9'd2, 1'b1);
        wait_done("gaps_done");
        tests_run++;
        if (smp_cnt !== 17'd2 || err_cnt !== 17'd2 || sae !== 26'd4 || wce !== 9'd2) begin
            fails++;
            $display("FAIL gaps_stats: smp=%0d err=%0d sae=%0d wce=%0d want 2 2 4 2",
                     smp_cnt, err_cnt, sae, wce);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_three_beats();
        test_done_drop();
        test_nmax();
        test_start_in_run();
        test_reset_mid_run();
        test_back_to_back_gaps();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
